// File: rtl/exec_logic_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : exec_logic_arbiter_if
//  Description : Issue-port and result-port bundle for the logic-unit arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface exec_logic_arbiter_if #(
    parameter int W_OPR = 32,
    parameter int W_TAG = 4
);
    logic             req0_valid_i;
    logic             req0_ready_o;
    logic [W_OPR-1:0] req0_opr0_i;
    logic [W_OPR-1:0] req0_opr1_i;
    logic [1:0]       req0_sel_i;
    logic [W_TAG-1:0] req0_tag_i;

    logic             req1_valid_i;
    logic             req1_ready_o;
    logic [W_OPR-1:0] req1_opr0_i;
    logic [W_OPR-1:0] req1_opr1_i;
    logic [1:0]       req1_sel_i;
    logic [W_TAG-1:0] req1_tag_i;

    logic             res_valid_o;
    logic             res_ready_i;
    logic [W_OPR-1:0] res_data_o;
    logic [W_TAG-1:0] res_tag_o;
    logic             res_src_o;

    // Requesters and result consumer
    modport master (
        output req0_valid_i, req0_opr0_i, req0_opr1_i, req0_sel_i, req0_tag_i,
        input  req0_ready_o,
        output req1_valid_i, req1_opr0_i, req1_opr1_i, req1_sel_i, req1_tag_i,
        input  req1_ready_o,
        input  res_valid_o, res_data_o, res_tag_o, res_src_o,
        output res_ready_i
    );

    // Arbiter side
    modport slave (
        input  req0_valid_i, req0_opr0_i, req0_opr1_i, req0_sel_i, req0_tag_i,
        output req0_ready_o,
        input  req1_valid_i, req1_opr0_i, req1_opr1_i, req1_sel_i, req1_tag_i,
        output req1_ready_o,
        output res_valid_o, res_data_o, res_tag_o, res_src_o,
        input  res_ready_i
    );
endinterface
`default_nettype wire

// File: rtl/exec_logic_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : exec_logic_arbiter
//  Description : Shares one AND/OR/NOT/XOR unit between two issue requesters
//                and registers the result behind a valid/ready handshake.
//                Define EXEC_LOGIC_ARB_RR_EN for round-robin arbitration;
//                otherwise requester 0 has fixed priority.
//  Revision    : 1.0 - initial release
// ============================================================================
module exec_logic_arbiter #(
    parameter int W_OPR = 32,
    parameter int W_TAG = 4
) (
    input  wire                  clk,
    input  wire                  rst_n,
    exec_logic_arbiter_if.slave  bus
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    localparam logic [1:0] SEL_AND = 2'b00;
    localparam logic [1:0] SEL_OR  = 2'b01;
    localparam logic [1:0] SEL_NOT = 2'b10;

    logic [0:0]       state_q, state_d;
    logic [W_OPR-1:0] data_q,  data_d;
    logic [W_TAG-1:0] tag_q,   tag_d;
    logic             src_q,   src_d;

    logic             w_out_free;
    logic             w_gnt_any;
    logic             w_gnt_idx;
    logic             w_accept;
    logic [W_OPR-1:0] w_opa;
    logic [W_OPR-1:0] w_opb;
    logic [1:0]       w_sel;
    logic [W_TAG-1:0] w_tag;
    logic [W_OPR-1:0] w_result;

    assign w_out_free = (state_q == ST_EMPTY) || bus.res_ready_i;
    assign w_gnt_any  = bus.req0_valid_i || bus.req1_valid_i;
    assign w_accept   = w_gnt_any && w_out_free;

`ifdef EXEC_LOGIC_ARB_RR_EN
    logic ptr_q, ptr_d;

    // Pointer only matters on contention; a lone requester always wins
    always_comb begin
        if (bus.req0_valid_i && bus.req1_valid_i) begin
            w_gnt_idx = ptr_q;
        end else begin
            w_gnt_idx = bus.req1_valid_i;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (w_accept) begin
            ptr_d = ~w_gnt_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign w_gnt_idx = bus.req1_valid_i && !bus.req0_valid_i;
`endif

    // Ready is forced low during reset since the empty register would otherwise look free
    assign bus.req0_ready_o = rst_n && w_accept && !w_gnt_idx;
    assign bus.req1_ready_o = rst_n && w_accept &&  w_gnt_idx;

    // Idle grant index is 0, so requester 0 drives the unit when nobody is granted
    assign w_opa = w_gnt_idx ? bus.req1_opr0_i : bus.req0_opr0_i;
    assign w_opb = w_gnt_idx ? bus.req1_opr1_i : bus.req0_opr1_i;
    assign w_sel = w_gnt_idx ? bus.req1_sel_i  : bus.req0_sel_i;
    assign w_tag = w_gnt_idx ? bus.req1_tag_i  : bus.req0_tag_i;

    always_comb begin
        case (w_sel)
            SEL_AND: w_result = w_opa & w_opb;
            SEL_OR:  w_result = w_opa | w_opb;
            SEL_NOT: w_result = ~w_opa;
            default: w_result = w_opa ^ w_opb;
        endcase
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        tag_d   = tag_q;
        src_d   = src_q;
        if (w_accept) begin
            state_d = ST_FULL;
            data_d  = w_result;
            tag_d   = w_tag;
            src_d   = w_gnt_idx;
        end else if ((state_q == ST_FULL) && bus.res_ready_i) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            tag_q   <= '0;
            src_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
            src_q   <= src_d;
        end
    end

    assign bus.res_valid_o = (state_q == ST_FULL);
    assign bus.res_data_o  = data_q;
    assign bus.res_tag_o   = tag_q;
    assign bus.res_src_o   = src_q;

endmodule
`default_nettype wire

// File: tb/tb_exec_logic_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exec_logic_arbiter
//  Description : Directed scoreboard bench for exec_logic_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_exec_logic_arbiter;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  t;
        logic        s;
    } res_t;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    res_t sb_q[$];
    res_t m_last;
    logic m_full;
`ifdef EXEC_LOGIC_ARB_RR_EN
    logic m_ptr;
`endif
    logic hist[4];

    exec_logic_arbiter_if #(.W_OPR(32), .W_TAG(4)) bus ();

    exec_logic_arbiter #(.W_OPR(32), .W_TAG(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] f_unit(input logic [1:0] s, input logic [31:0] a, input logic [31:0] b);
        case (s)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return ~a;
            default: return a ^ b;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
        end
    endtask

    // One clock: check readies against the model, push the expected result, check outputs after the edge
    task automatic cycle();
        logic v0, v1, free, gi, acc, rr;
        res_t e;
        #1;
        v0   = bus.req0_valid_i;
        v1   = bus.req1_valid_i;
        rr   = bus.res_ready_i;
        free = !m_full || rr;
`ifdef EXEC_LOGIC_ARB_RR_EN
        gi = (v0 && v1) ? m_ptr : v1;
`else
        gi = !v0 && v1;
`endif
        acc = free && (v0 || v1);
        chk("req0_ready", bus.req0_ready_o, acc && !gi);
        chk("req1_ready", bus.req1_ready_o, acc && gi);
        if (acc) begin
            if (gi) begin
                e.d = f_unit(bus.req1_sel_i, bus.req1_opr0_i, bus.req1_opr1_i);
                e.t = bus.req1_tag_i;
            end else begin
                e.d = f_unit(bus.req0_sel_i, bus.req0_opr0_i, bus.req0_opr1_i);
                e.t = bus.req0_tag_i;
            end
            e.s = gi;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (acc) begin
            m_last = sb_q.pop_front();
            m_full = 1'b1;
`ifdef EXEC_LOGIC_ARB_RR_EN
            m_ptr  = ~gi;
`endif
        end else if (m_full && rr) begin
            m_full = 1'b0;
        end
        chk("res_valid", bus.res_valid_o, m_full);
        chk("res_data",  bus.res_data_o,  m_last.d);
        chk("res_tag",   bus.res_tag_o,   m_last.t);
        chk("res_src",   bus.res_src_o,   m_last.s);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        m_full   = 1'b0;
        m_last   = '0;
`ifdef EXEC_LOGIC_ARB_RR_EN
        m_ptr    = 1'b0;
`endif
        rst_n = 1'b0;
        bus.req0_valid_i = 1'b1;
        bus.req0_opr0_i  = 32'h1111_2222;
        bus.req0_opr1_i  = 32'h3333_4444;
        bus.req0_sel_i   = 2'b00;
        bus.req0_tag_i   = 4'd0;
        bus.req1_valid_i = 1'b0;
        bus.req1_opr0_i  = '0;
        bus.req1_opr1_i  = '0;
        bus.req1_sel_i   = 2'b00;
        bus.req1_tag_i   = 4'd0;
        bus.res_ready_i  = 1'b1;

        // Reset state
        #2;
        chk("rst_valid",  bus.res_valid_o,  1'b0);
        chk("rst_data",   bus.res_data_o,   32'h0);
        chk("rst_tag",    bus.res_tag_o,    4'h0);
        chk("rst_src",    bus.res_src_o,    1'b0);
        chk("rst_ready0", bus.req0_ready_o, 1'b0);
        bus.req0_valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single XOR from requester 0
        bus.req0_valid_i = 1'b1;
        bus.req0_opr0_i  = 32'hF0F0_00FF;
        bus.req0_opr1_i  = 32'h0FF0_0F0F;
        bus.req0_sel_i   = 2'b11;
        bus.req0_tag_i   = 4'd3;
        cycle();
        chk("xor_lit", bus.res_data_o, 32'hFF00_0FF0);
        chk("xor_tag", bus.res_tag_o,  4'd3);
        bus.req0_valid_i = 1'b0;

        // AND / OR / NOT from requester 1, back to back
        bus.req1_valid_i = 1'b1;
        bus.req1_opr0_i  = 32'h1234_5678;
        bus.req1_opr1_i  = 32'h0000_FFFF;
        bus.req1_tag_i   = 4'd7;
        bus.req1_sel_i   = 2'b00;
        cycle();
        chk("and_lit", bus.res_data_o, 32'h0000_5678);
        bus.req1_sel_i   = 2'b01;
        cycle();
        chk("or_lit", bus.res_data_o, 32'h1234_FFFF);
        bus.req1_sel_i   = 2'b10;
        cycle();
        chk("not_lit", bus.res_data_o, 32'hEDCB_A987);
        chk("not_src", bus.res_src_o, 1'b1);
        bus.req1_valid_i = 1'b0;

        // Drain with no requests
        cycle();
        chk("drain_hold", bus.res_data_o, 32'hEDCB_A987);

        // Contention for four cycles
        bus.req0_valid_i = 1'b1;
        bus.req0_opr0_i  = 32'hAAAA_5555;
        bus.req0_opr1_i  = 32'h0F0F_0F0F;
        bus.req0_sel_i   = 2'b01;
        bus.req0_tag_i   = 4'd1;
        bus.req1_valid_i = 1'b1;
        bus.req1_opr0_i  = 32'hCAFE_BABE;
        bus.req1_opr1_i  = 32'hFFFF_0000;
        bus.req1_sel_i   = 2'b11;
        bus.req1_tag_i   = 4'd2;
        for (int i = 0; i < 4; i++) begin
            cycle();
            hist[i] = bus.res_src_o;
        end
`ifdef EXEC_LOGIC_ARB_RR_EN
        chk("cont_src0", hist[0], 1'b0);
        chk("cont_src1", hist[1], 1'b1);
        chk("cont_src2", hist[2], 1'b0);
        chk("cont_src3", hist[3], 1'b1);
`else
        chk("cont_src0", hist[0], 1'b0);
        chk("cont_src1", hist[1], 1'b0);
        chk("cont_src2", hist[2], 1'b0);
        chk("cont_src3", hist[3], 1'b0);
`endif

        // Backpressure while FULL
        bus.req1_valid_i = 1'b0;
        bus.res_ready_i  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
        end
        bus.res_ready_i  = 1'b1;
        cycle();
        chk("bp_src", bus.res_src_o, 1'b0);
        bus.req0_valid_i = 1'b0;
        cycle();

        // Reset while holding a result with tag 5
        bus.req0_valid_i = 1'b1;
        bus.req0_sel_i   = 2'b00;
        bus.req0_tag_i   = 4'd5;
        cycle();
        chk("pre_rst_tag", bus.res_tag_o, 4'd5);
        bus.req0_valid_i = 1'b0;
        bus.res_ready_i  = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", bus.res_valid_o, 1'b0);
        chk("arst_tag",   bus.res_tag_o,   4'h0);
        chk("arst_data",  bus.res_data_o,  32'h0);
        bus.req0_valid_i = 1'b1;
        bus.req1_valid_i = 1'b1;
        bus.res_ready_i  = 1'b1;
        #1;
        chk("arst_ready0", bus.req0_ready_o, 1'b0);
        chk("arst_ready1", bus.req1_ready_o, 1'b0);
        m_full = 1'b0;
        m_last = '0;
`ifdef EXEC_LOGIC_ARB_RR_EN
        m_ptr  = 1'b0;
`endif
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        chk("post_rst_src", bus.res_src_o, 1'b0);
        bus.req0_valid_i = 1'b0;
        bus.req1_valid_i = 1'b0;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
